// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multicycle CPU memory responder.
package mem_responder_pkg;

    localparam int unsigned MR_STATE_WIDTH = 2;
    localparam int unsigned MR_WORD_BEATS  = 4;
    localparam int unsigned MR_CNT_WIDTH   = 2;

    typedef enum logic [MR_STATE_WIDTH-1:0] {
        MR_STATE_IDLE  = 2'd0,
        MR_STATE_ISSUE = 2'd1,
        MR_STATE_WAIT  = 2'd2,
        MR_STATE_DONE  = 2'd3
    } mr_state_e;

    typedef enum logic [1:0] {
        MR_OP_WORD_RD = 2'd0,
        MR_OP_BYTE_RD = 2'd1,
        MR_OP_BYTE_WR = 2'd2
    } mr_op_e;

    // Rejected requests: conflicting strobes or a misaligned instruction fetch.
    function automatic logic mr_bad_request(input logic rd, input logic wr,
                                            input logic iord, input logic [1:0] lsb);
        return (rd && wr) || (rd && !iord && (lsb != 2'd0));
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Behavioural byte-wide backing RAM: synchronous read (one-cycle latency), synchronous write.
module mem_byte_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Read returns the pre-write contents on a same-address write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Turns memread/memwrite/iord strobes into byte-RAM beat sequences and
// returns a one-cycle ready_o pulse (with err_o) on completion.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              iord_i,
    input  logic [31:0]       addr_i,
    input  logic [7:0]        wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i
);

    mr_state_e                state_q, state_d;
    mr_op_e                   op_q, op_d;
    logic [RAM_AW-1:0]        base_q, base_d;
    logic [MR_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]              stage_q, stage_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     ready_q, ready_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic [RAM_AW-1:0]        ram_addr_q, ram_addr_d;
    logic                     ram_we_q, ram_we_d;
    logic [7:0]               ram_wdata_q, ram_wdata_d;
    logic [MR_CNT_WIDTH-1:0]  cnt_next;
    logic                     unused_addr_hi;

    assign unused_addr_hi = ^addr_i[31:RAM_AW];
    assign cnt_next       = cnt_q + MR_CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= MR_STATE_IDLE;
            op_q        <= MR_OP_WORD_RD;
            base_q      <= '0;
            cnt_q       <= '0;
            stage_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            MR_STATE_IDLE: begin
                if (memread_i || memwrite_i) begin
                    base_d = addr_i[RAM_AW-1:0];
                    cnt_d  = '0;
                    op_d   = memwrite_i ? MR_OP_BYTE_WR
                           : (iord_i ? MR_OP_BYTE_RD : MR_OP_WORD_RD);
                    if (mr_bad_request(memread_i, memwrite_i, iord_i, addr_i[1:0])) begin
                        state_d = MR_STATE_DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        // First beat is registered here so it is on the RAM port in ISSUE.
                        state_d    = MR_STATE_ISSUE;
                        ram_addr_d = addr_i[RAM_AW-1:0];
                        if (memwrite_i) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = wdata_i;
                        end
                    end
                end
            end
            MR_STATE_ISSUE: begin
                unique case (op_q)
                    MR_OP_WORD_RD: begin
                        cnt_d = cnt_next;
                        // Byte from the previous beat arrives now; big-endian lanes.
                        unique case (cnt_q)
                            2'd1:    stage_d[31:24] = ram_rdata_i;
                            2'd2:    stage_d[23:16] = ram_rdata_i;
                            2'd3:    stage_d[15:8]  = ram_rdata_i;
                            default: ;
                        endcase
                        if (cnt_q == MR_CNT_WIDTH'(MR_WORD_BEATS - 1)) begin
                            state_d = MR_STATE_WAIT;
                        end else begin
                            ram_addr_d = base_q + RAM_AW'(cnt_next);
                        end
                    end
                    MR_OP_BYTE_RD: begin
                        state_d = MR_STATE_WAIT;
                    end
                    default: begin
                        state_d = MR_STATE_DONE;
                        ready_d = 1'b1;
                    end
                endcase
            end
            MR_STATE_WAIT: begin
                state_d = MR_STATE_DONE;
                ready_d = 1'b1;
                rdata_d = (op_q == MR_OP_WORD_RD) ? {stage_q[31:8], ram_rdata_i}
                                                  : {24'd0, ram_rdata_i};
            end
            default: begin
                state_d = MR_STATE_IDLE;
            end
        endcase

        busy_d = (state_d != MR_STATE_IDLE);
    end

    assign rdata_o     = rdata_q;
    assign ready_o     = ready_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_we_o    = ram_we_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a memory-array model predicts completion
// cycle, err and rdata per request plus the RAM port trace; a monitor checks them.
module tb_mem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int unsigned cyc;
        logic [9:0]  addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          memread = 1'b0;
    logic          memwrite = 1'b0;
    logic          iord = 1'b0;
    logic [31:0]   addr = '0;
    logic [7:0]    wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned last_ready_cyc = 32'hFFFF_FFFF;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] last_rdata = '0;
    exp_t        sb_q[$];
    beat_t       beat_q[$];

    mem_responder #(.RAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .memread_i(memread), .memwrite_i(memwrite), .iord_i(iord),
        .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .ready_o(ready), .err_o(err), .busy_o(busy),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    mem_byte_ram #(.AW(AW)) u_ram (
        .clk(clk), .we_i(ram_we), .addr_i(ram_addr),
        .wdata_i(ram_wdata), .rdata_o(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what the access should do, from address/byte semantics alone.
    task automatic model_issue(input logic rd, input logic wr, input logic iord_m,
                               input logic [31:0] a32, input logic [7:0] wd,
                               input int unsigned c);
        exp_t        e;
        beat_t       b;
        int unsigned a;
        a     = a32 % DEPTH;
        e.err = 1'b0;
        if ((rd && wr) || (rd && !iord_m && (a32 % 4 != 0))) begin
            e.cyc = c + 1;
            e.err = 1'b1;
        end else if (wr) begin
            e.cyc = c + 2;
            b.cyc = c + 1; b.addr = 10'(a); b.we = 1'b1; b.wdata = wd;
            beat_q.push_back(b);
            ref_mem[a] = wd;
        end else if (iord_m) begin
            e.cyc = c + 3;
            b.cyc = c + 1; b.addr = 10'(a); b.we = 1'b0; b.wdata = '0;
            beat_q.push_back(b);
            last_rdata = {24'd0, ref_mem[a]};
        end else begin
            e.cyc = c + 6;
            last_rdata = '0;
            for (int k = 0; k < 4; k++) begin
                b.cyc = c + 1 + k; b.addr = 10'((a + k) % DEPTH); b.we = 1'b0; b.wdata = '0;
                beat_q.push_back(b);
                last_rdata = (last_rdata << 8) | 32'(ref_mem[(a + k) % DEPTH]);
            end
        end
        e.data = last_rdata;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; holds the request until ready_o is seen.
    task automatic access(input logic rd, input logic wr, input logic io,
                          input logic [31:0] a, input logic [7:0] wd);
        int unsigned c;
        int unsigned n;
        c        = (cyc == last_ready_cyc) ? cyc + 1 : cyc;
        memread  = rd;
        memwrite = wr;
        iord     = io;
        addr     = a;
        wdata    = wd;
        model_issue(rd, wr, io, a, wd, c);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (cyc == c + 1) chk("busy_after_accept", 32'(busy), 32'd1);
        end while (!ready && n < 20);
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout addr 0x%0h: no ready_o within 20 cycles", a);
        end
        last_ready_cyc = cyc;
    endtask

    task automatic idle(input int unsigned n);
        memread  = 1'b0;
        memwrite = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    // Monitor: completion responses and the RAM-port beat trace.
    always @(negedge clk) begin
        exp_t  e;
        beat_t b;
        logic  exp_we;
        if (ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ready_cycle", cyc, e.cyc);
                chk("err", 32'(err), 32'(e.err));
                chk("rdata", rdata, e.data);
            end
        end else if (err) begin
            chk("err_without_ready", 32'(err), 32'd0);
        end
        exp_we = 1'b0;
        while (beat_q.size() > 0 && beat_q[0].cyc <= cyc) begin
            b = beat_q.pop_front();
            chk("ram_addr", 32'(ram_addr), 32'(b.addr));
            if (b.we) begin
                exp_we = 1'b1;
                chk("ram_wdata", 32'(ram_wdata), 32'(b.wdata));
            end
        end
        if (ram_we || exp_we) chk("ram_we", 32'(ram_we), 32'(exp_we));
    end

    initial begin
        logic [7:0]  v;
        logic [31:0] a;
        int unsigned k;
        int unsigned c;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Fill the whole RAM through the responder; a few locations get known bytes.
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = 8'($urandom);
            case (i)
                'h010: v = 8'h12;  'h011: v = 8'h34;  'h012: v = 8'h56;  'h013: v = 8'h78;
                'h3FC: v = 8'hC1;  'h3FD: v = 8'hC2;  'h3FE: v = 8'hA1;  'h3FF: v = 8'hA2;
                'h000: v = 8'hB1;  'h001: v = 8'hB2;
                default: ;
            endcase
            a = ($urandom & 32'hFFFF_FC00) | 32'(i);
            access(1'b0, 1'b1, 1'b1, a, v);
            idle($urandom_range(0, 1));
        end
        idle(2);

        access(1'b1, 1'b0, 1'b0, 32'h10, 8'h00);              // 0x12345678
        idle(1);
        access(1'b1, 1'b0, 1'b1, 32'h13, 8'h00);              // 0x00000078
        idle(1);
        access(1'b0, 1'b1, 1'b1, 32'h21, 8'hAB);
        access(1'b1, 1'b0, 1'b1, 32'h21, 8'h00);              // back-to-back, 0xAB
        idle(1);
        access(1'b1, 1'b0, 1'b0, 32'h12, 8'h00);              // misaligned fetch
        idle(1);
        access(1'b1, 1'b1, 1'b1, 32'h40, 8'h55);              // both strobes
        idle(1);
        access(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 8'h00);       // top-of-RAM word
        idle(1);
        access(1'b1, 1'b0, 1'b0, 32'h0000_03FE, 8'h00);       // misaligned at top
        access(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);               // back-to-back word
        idle(2);

        // Reset three cycles into a word fetch abandons it.
        c = cyc;
        memread = 1'b1; iord = 1'b0; addr = 32'h10;
        repeat (3) @(negedge clk);
        rst = 1'b0; memread = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b1;
        last_rdata = '0;
        idle(8);
        chk("midreset_span", cyc - c, 32'd12);
        access(1'b1, 1'b0, 1'b1, 32'h10, 8'h00);              // 0x00000012
        idle(1);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            a = $urandom;
            case (k)
                0, 1, 2: access(1'b1, 1'b0, 1'b0, a & 32'hFFFF_FFFC, 8'h00);
                3:       access(1'b1, 1'b0, 1'b0, a, 8'h00);
                4, 5:    access(1'b1, 1'b0, 1'b1, a, 8'h00);
                6, 7:    access(1'b0, 1'b1, 1'b1, a, 8'($urandom));
                8:       access(1'b1, 1'b1, 1'($urandom), a, 8'($urandom));
                default: access(1'b1, 1'b0, 1'b0, (a & 32'hFFFF_FC00) | 32'h3FC, 8'h00);
            endcase
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("sb_drained", sb_q.size(), 32'd0);
        chk("beats_drained", beat_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
